// File: rtl/mr_fetch_pkg.sv
// Shared types and constants for the mr_fetch_unit instruction fetch stage.
// MR_FETCH_PREFETCH_EN selects a two-entry prefetch queue instead of one.
package mr_fetch_pkg;

   localparam int MR_FETCH_WIDTH = 16;

`ifdef MR_FETCH_PREFETCH_EN
   localparam int MR_FETCH_QDEPTH = 2;
`else
   localparam int MR_FETCH_QDEPTH = 1;
`endif

   // Queue occupancy is held in a 2-bit counter
   localparam logic [1:0] MR_FETCH_QCNT = 2'(MR_FETCH_QDEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DROP,
      S_FULL
   } state_e;

endpackage

// File: rtl/mr_fetch_queue.sv
// One- or two-entry FIFO of {pc, instr} pairs between fetch and decode.
// Flush empties the queue and overrides a push in the same cycle.
module mr_fetch_queue
   import mr_fetch_pkg::*;
#(
   parameter int W = MR_FETCH_WIDTH
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] push_pc,
   input  logic [W-1:0] push_instr,
   output logic [W-1:0] head_pc,
   output logic [W-1:0] head_instr,
   output logic         full,
   output logic         empty
);

   localparam int D = MR_FETCH_QDEPTH;

   logic [W-1:0] pc_q    [D];
   logic [W-1:0] pc_d    [D];
   logic [W-1:0] instr_q [D];
   logic [W-1:0] instr_d [D];
   logic [1:0]   cnt_q;
   logic [1:0]   cnt_d;

   assign empty      = (cnt_q == 2'd0);
   assign full       = (cnt_q == MR_FETCH_QCNT);
   assign head_pc    = pc_q[0];
   assign head_instr = instr_q[0];

   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      cnt_d   = cnt_q;
      if (flush) begin
         cnt_d = 2'd0;
      end else begin
         // Entry 0 is always the head; a pop shifts the tail forward
         if (pop && !empty) begin
            pc_d[0]    = pc_q[D-1];
            instr_d[0] = instr_q[D-1];
            cnt_d      = cnt_q - 2'd1;
         end
         if (push && (cnt_d != MR_FETCH_QCNT)) begin
            for (int i = 0; i < D; i++) begin
               if (2'(i) == cnt_d) begin
                  pc_d[i]    = push_pc;
                  instr_d[i] = push_instr;
               end
            end
            cnt_d = cnt_d + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 2'd0;
         for (int i = 0; i < D; i++) begin
            pc_q[i]    <= '0;
            instr_q[i] <= '0;
         end
      end else begin
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

endmodule

// File: rtl/mr_fetch_unit.sv
// Instruction fetch stage: memory request FSM, PC control and decode queue.
// Define MR_FETCH_PREFETCH_EN for a two-entry queue that keeps fetching.
module mr_fetch_unit
   import mr_fetch_pkg::*;
#(
   parameter int WIDTH = MR_FETCH_WIDTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] PC,
   output logic             ST,
   output logic [WIDTH-1:0] ADDR,
   output logic             ENA,
   output logic             MEM_REQ,
   output logic [WIDTH-1:0] MEM_ADDR,
   input  logic             MEM_ACK,
   input  logic [WIDTH-1:0] MEM_DATA,
   output logic [WIDTH-1:0] IR,
   output logic [WIDTH-1:0] IR_PC,
   output logic             IR_VALID,
   input  logic             IR_READY,
   input  logic             BR_TAKEN,
   input  logic [WIDTH-1:0] BR_TARGET
);

   state_e           state_q;
   state_e           state_d;
   logic [WIDTH-1:0] mem_addr_q;
   logic [WIDTH-1:0] mem_addr_d;
   logic             redir;
   logic             accept;
   logic             full_nx;
   logic             q_pop;
   logic             q_full;
   logic             q_empty;

   assign redir = BR_TAKEN & ~RST;
   assign q_pop = ~q_empty & IR_READY & ~redir;

   always_comb begin
      state_d    = state_q;
      mem_addr_d = mem_addr_q;
      accept     = 1'b0;
      // Occupancy after an accept; S_REQ never sees a full queue
      full_nx    = q_empty ? (MR_FETCH_QCNT == 2'd1) : ~q_pop;
      unique case (state_q)
         S_IDLE: begin
            state_d    = S_REQ;
            mem_addr_d = redir ? BR_TARGET : PC;
         end
         S_REQ: begin
            if (redir) begin
               if (MEM_ACK) begin
                  mem_addr_d = BR_TARGET;
               end else begin
                  state_d = S_DROP;
               end
            end else if (MEM_ACK) begin
               accept = 1'b1;
               if (full_nx) begin
                  state_d = S_FULL;
               end else begin
                  mem_addr_d = PC + WIDTH'(1);
               end
            end
         end
         S_DROP: begin
            // Address stays put until the stale read completes
            if (MEM_ACK) begin
               state_d    = S_REQ;
               mem_addr_d = redir ? BR_TARGET : PC;
            end
         end
         S_FULL: begin
            if (redir) begin
               state_d    = S_REQ;
               mem_addr_d = BR_TARGET;
            end else if (q_pop || !q_full) begin
               state_d    = S_REQ;
               mem_addr_d = PC;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= S_IDLE;
         mem_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   assign ST       = redir;
   assign ENA      = redir | accept;
   assign ADDR     = redir ? BR_TARGET : '0;
   assign MEM_REQ  = (state_q == S_REQ) | (state_q == S_DROP);
   assign MEM_ADDR = mem_addr_q;
   assign IR_VALID = ~q_empty;

   mr_fetch_queue #(
      .W(WIDTH)
   ) u_queue (
      .clk        (CLK),
      .rst        (RST),
      .push       (accept),
      .pop        (q_pop),
      .flush      (redir),
      .push_pc    (mem_addr_q),
      .push_instr (MEM_DATA),
      .head_pc    (IR_PC),
      .head_instr (IR),
      .full       (q_full),
      .empty      (q_empty)
   );

endmodule

// File: doc/mr_fetch_unit.md
MR_FETCH_UNIT -- requirements
Module: mr_fetch_unit

Interface
REQ-001 Parameter: WIDTH, 16, address/instruction width; all WIDTH-wide ports below use it.
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 RST  in  1  asynchronous, active-high reset; shared with the program counter.
REQ-004 PC  in  WIDTH  current program-counter value.
REQ-005 ST  out  1  load strobe to the program counter.
REQ-006 ADDR  out  WIDTH  load value to the program counter.
REQ-007 ENA  out  1  program-counter advance/load enable.
REQ-008 MEM_REQ  out  1  instruction-memory read request.
REQ-009 MEM_ADDR  out  WIDTH  read address; registered.
REQ-010 MEM_ACK  in  1  read complete; MEM_DATA valid in the same cycle.
REQ-011 MEM_DATA  in  WIDTH  read data.
REQ-012 IR  out  WIDTH  instruction to decode.
REQ-013 IR_PC  out  WIDTH  address of IR.
REQ-014 IR_VALID  out  1  IR/IR_PC valid.
REQ-015 IR_READY  in  1  decode accepts IR when IR_VALID and IR_READY are both high.
REQ-016 BR_TAKEN  in  1  single-cycle redirect request.
REQ-017 BR_TARGET  in  WIDTH  redirect address.

Function
REQ-018 FSM states: S_IDLE, S_REQ, S_DROP, S_FULL.
- S_IDLE goes to S_REQ after one cycle.
- Entry to S_REQ latches MEM_ADDR <= PC.
REQ-019 Memory handshake rules:
- MEM_REQ is high in S_REQ and S_DROP only.
- MEM_ADDR is stable while MEM_REQ is high.
- A request ends only on MEM_ACK=1.
REQ-020 MEM_ACK in S_REQ without BR_TAKEN (fetch accept):
- push {MEM_ADDR, MEM_DATA} into the queue;
- ENA=1 combinationally in that cycle, so PC increments on the same edge;
- next state is S_FULL if the queue becomes full, else S_REQ with a new address latch.
REQ-021 ST=0 and ENA=0 in every cycle that is neither a fetch accept nor a redirect.
REQ-022 Fetch latency: MEM_ACK at edge N gives IR_VALID=1 after edge N+1 when the queue was empty.
REQ-023 Queue pop: on IR_VALID && IR_READY. In S_FULL, a pop moves the FSM to S_REQ on the next edge.
REQ-024 Redirect: BR_TAKEN=1 drives ST=1, ENA=1 and ADDR=BR_TARGET combinationally, and flushes the queue (IR_VALID=0 next cycle).
REQ-025 Redirect next state:
- S_REQ with MEM_ACK=0 goes to S_DROP; the old address is held until MEM_ACK, then the FSM goes to S_REQ and the returned data is discarded.
- S_REQ with MEM_ACK=1 in the same cycle: data discarded, next state S_REQ.
- S_FULL or S_IDLE goes to S_REQ.
REQ-026 A redirect has priority over a fetch accept and over a pop in the same cycle.
REQ-027 ADDR=0 whenever ST=0.
REQ-028 MEM_ACK in S_IDLE or S_FULL is ignored.

Reset
REQ-029 While RST is high: state=S_IDLE; IR, IR_PC, MEM_ADDR = 0; IR_VALID, MEM_REQ, ST, ENA = 0; queue empty.
REQ-030 RST asserted mid-request abandons the request without waiting for MEM_ACK.

Configuration
REQ-031 MR_FETCH_PREFETCH_EN defined: queue depth 2; fetching continues while one entry awaits decode.
REQ-032 MR_FETCH_PREFETCH_EN undefined: queue depth 1; at most one instruction is held, and no request is issued while it is held.

Structure
REQ-033 Package mr_fetch_pkg holds:
- the state enum;
- the WIDTH default;
- the MR_FETCH_QDEPTH constant (1 or 2, selected by the macro).
REQ-034 Sub-module mr_fetch_queue: 1/2-entry FIFO of {pc, instr} with push, pop, flush, full, empty; flush overrides push.

Verification
REQ-035 Reset release, PC=0x0000, MEM_ACK one cycle after MEM_REQ, IR_READY=1:
- MEM_ADDR=0x0000 then 0x0001;
- IR_PC sequence 0x0000, 0x0001;
- one ENA pulse per fetch.
REQ-036 IR_READY=0 with depth 1:
- after the first ACK, MEM_REQ=0 and IR is held stable;
- raise IR_READY: next request at PC+1.
- Depth 2: exactly two fetches, then stall.
REQ-037 BR_TAKEN with BR_TARGET=0x0040 while MEM_REQ is pending for 0x0005 and ACK is 3 cycles late:
- ST=1, ENA=1 in the branch cycle;
- MEM_ADDR stays 0x0005 until ACK;
- that data is never presented;
- next MEM_ADDR=0x0040.
REQ-038 BR_TAKEN and MEM_ACK in the same cycle:
- ACK data dropped;
- IR_VALID=0 next cycle;
- next fetch at BR_TARGET.
REQ-039 RST asserted during S_REQ:
- all outputs 0 asynchronously;
- a late MEM_ACK after release, in S_IDLE, is ignored.
REQ-040 PC=0xFFFF fetch with ENA: IR_PC=0xFFFF, next MEM_ADDR=0x0000 (wrap).
